debounce_sync_df: RTL and testbench



---
 rtl/debounce_sync_df.sv | 135 +++++++++++++
 tb/tb_debounce_sync_df.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/debounce_sync_df.sv
// debounce_sync_df
//   Conditions a raw asynchronous input (button/switch) into a clean level
//   for the downstream dataflow NOT gate. A 2-flop synchroniser removes
//   metastability, then a counted-stability FSM removes bounce.
//
// Ports
//   clk    in   single clock for all state
//   rst_n  in   asynchronous active-low reset
//   a      in   raw asynchronous input
//   tick   in   sample qualifier; the stability counter advances only on tick=1
//   y      out  debounced level
//   rise   out  one-cycle pulse on a y 0->1 transition
//   fall   out  one-cycle pulse on a y 1->0 transition
//   busy   out  high while a candidate transition is being qualified
module debounce_sync_df #(
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic tick,
    output logic y,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_CHK_H = 2'd1,
        ST_HIGH  = 2'd2,
        ST_CHK_L = 2'd3
    } state_t;

    // Terminal count at counter width; reaching it on a qualified sample
    // completes the transition, so the counter never wraps.
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic             r_y;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

    assign y    = r_y;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_LOW;
            r_y     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_s1   <= a;
            r_s2   <= r_s1;
            // Pulses are single-cycle: cleared every cycle unless set below.
            r_rise <= 1'b0;
            r_fall <= 1'b0;

            case (r_state)
                ST_LOW: begin
                    if (r_s2) begin
                        r_state <= ST_CHK_H;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_CHK_H: begin
                    // Abort wins over completion and ignores tick.
                    if (!r_s2) begin
                        r_state <= ST_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (tick) begin
                        if (r_cnt == LP_LAST) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_y     <= 1'b1;
                            r_rise  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                ST_HIGH: begin
                    if (!r_s2) begin
                        r_state <= ST_CHK_L;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_CHK_L: begin
                    if (r_s2) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (tick) begin
                        if (r_cnt == LP_LAST) begin
                            r_state <= ST_LOW;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_y     <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_LOW;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_y     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_sync_df.sv
// tb_debounce_sync_df
//   Directed bench for debounce_sync_df. Two instances share the stimulus:
//   u0 with DEBOUNCE_CYCLES=4 and u1 with DEBOUNCE_CYCLES=1.
module tb_debounce_sync_df;

    logic clk;
    logic rst_n;
    logic a;
    logic tick;
    logic y0, rise0, fall0, busy0;
    logic y1, rise1, fall1, busy1;

    int n_chk = 0;
    int n_err = 0;

    debounce_sync_df #(.CNT_W(16), .DEBOUNCE_CYCLES(4)) u0 (
        .clk(clk), .rst_n(rst_n), .a(a), .tick(tick),
        .y(y0), .rise(rise0), .fall(fall0), .busy(busy0)
    );

    debounce_sync_df #(.CNT_W(16), .DEBOUNCE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a), .tick(tick),
        .y(y1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next active edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 1'b0;
        tick  = 1'b1;
        #12;
        // reset state
        chk("rst_y0", y0, 0);    chk("rst_rise0", rise0, 0);
        chk("rst_fall0", fall0, 0); chk("rst_busy0", busy0, 0);
        chk("rst_cnt0", u0.r_cnt, 0);
        chk("rst_y1", y1, 0);    chk("rst_busy1", busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("idle_y0", y0, 0);

        // 1: rising qualification, edge E = first edge sampling a=1
        a = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            chk($sformatf("t1_y0_%0d", n),    y0,    (n >= 6) ? 1 : 0);
            chk($sformatf("t1_rise0_%0d", n), rise0, (n == 6) ? 1 : 0);
            chk($sformatf("t1_busy0_%0d", n), busy0, (n >= 2 && n <= 5) ? 1 : 0);
            chk($sformatf("t1_fall0_%0d", n), fall0, 0);
            // 6: DEBOUNCE_CYCLES=1 build completes at E+3
            chk($sformatf("t6_y1_%0d", n),    y1,    (n >= 3) ? 1 : 0);
            chk($sformatf("t6_rise1_%0d", n), rise1, (n == 3) ? 1 : 0);
            chk($sformatf("t6_busy1_%0d", n), busy1, (n == 2) ? 1 : 0);
        end
        idle(3);
        chk("t1_hold_y0", y0, 1);

        // 2: falling qualification
        a = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step();
            chk($sformatf("t2_y0_%0d", n),    y0,    (n >= 6) ? 0 : 1);
            chk($sformatf("t2_fall0_%0d", n), fall0, (n == 6) ? 1 : 0);
            chk($sformatf("t2_rise0_%0d", n), rise0, 0);
            chk($sformatf("t2_y1_%0d", n),    y1,    (n >= 3) ? 0 : 1);
            chk($sformatf("t2_fall1_%0d", n), fall1, (n == 3) ? 1 : 0);
        end
        idle(3);

        // 3: bounce 1x3, 0x2, 1x2, then 0 held
        for (int n = 0; n < 14; n++) begin
            a = (n < 3 || n == 5 || n == 6) ? 1'b1 : 1'b0;
            step();
            chk($sformatf("t3_y0_%0d", n),    y0,    0);
            chk($sformatf("t3_rise0_%0d", n), rise0, 0);
            chk($sformatf("t3_busy0_%0d", n), busy0,
                (n == 2 || n == 3 || n == 4 || n == 7 || n == 8) ? 1 : 0);
        end
        chk("t3_state_low", u0.r_state, 0);
        idle(4);

        // 4: tick on every 3rd edge; qualified edges E+3, E+6, E+9, E+12
        a = 1'b1;
        for (int n = 0; n < 14; n++) begin
            tick = (n % 3 == 0) ? 1'b1 : 1'b0;
            step();
            chk($sformatf("t4_y0_%0d", n),    y0,    (n >= 12) ? 1 : 0);
            chk($sformatf("t4_rise0_%0d", n), rise0, (n == 12) ? 1 : 0);
            if (n >= 2 && n <= 11)
                chk($sformatf("t4_cnt0_%0d", n), u0.r_cnt, (n - 3 + 3) / 3 - ((n == 2) ? 0 : 0));
        end
        tick = 1'b1;

        // bring both back to LOW
        a = 1'b0;
        idle(10);
        chk("t5_pre_y0", y0, 0);
        chk("t5_pre_y1", y1, 0);

        // 5: reset in CHK_H with cnt=2 (after E+4)
        a = 1'b1;
        idle(5);
        chk("t5_cnt0_mid", u0.r_cnt, 2);
        chk("t5_busy0_mid", busy0, 1);
        chk("t5_y1_mid", y1, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy0", busy0, 0);
        chk("t5_rst_y0", y0, 0);
        chk("t5_rst_cnt0", u0.r_cnt, 0);
        chk("t5_rst_state0", u0.r_state, 0);
        chk("t5_rst_y1", y1, 0);
        chk("t5_rst_rise", rise0 | rise1 | fall0 | fall1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            chk($sformatf("t5_y0_%0d", n),    y0,    (n >= 6) ? 1 : 0);
            chk($sformatf("t5_rise0_%0d", n), rise0, (n == 6) ? 1 : 0);
            chk($sformatf("t5_y1_%0d", n),    y1,    (n >= 3) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
